// File: rtl/instruction_fetch.sv
// LEGv8 instruction fetch: PC, word-addressed instruction memory and a
// registered IF output with redirect, stall and halt handling.
module instruction_fetch #(
    parameter int MEM_WORDS = 256,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          PCSrc,
    input  logic [63:0]   BranchAddress,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    output logic [31:0]   InstructionI,
    output logic [63:0]   AddressI,
    output logic          if_valid,
    output logic [63:0]   pc,
    output logic          halted,
    output logic          fetch_fault
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic [63:0]   addr_q, addr_d;
    logic          valid_q, valid_d;
    logic          halted_q, halted_d;
    logic          fault_q, fault_d;

    logic [31:0]   mem [MEM_WORDS];
    logic [31:0]   word;
    logic          legal;

    // MEM_WORDS is a power of two, so the range check is an upper-bits test
    assign legal = (pc_q[1:0] == 2'b00) && (pc_q[63:AW+2] == '0);
    assign word  = mem[pc_q[AW+1:2]];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        unique case (state_q)
            BOOT: begin
                valid_d = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                if (PCSrc) begin
                    pc_d    = BranchAddress;
                    valid_d = 1'b0;
                end else if (stall) begin
                    valid_d = valid_q;
                end else if (!legal) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                    fault_d  = 1'b1;
                    valid_d  = 1'b0;
                end else if (word == 32'h0000_0000) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                    valid_d  = 1'b0;
                end else begin
                    instr_d = word;
                    addr_d  = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 64'd4;
                end
            end
            HALT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            pc_q     <= '0;
            instr_q  <= '0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    // Preload only while the fetch path is idle: in reset or halted
    always_ff @(posedge clk) begin
        if (load_en && (!rst_n || state_q == HALT)) begin
            mem[load_addr] <= load_data;
        end
    end

    assign InstructionI = instr_q;
    assign AddressI     = addr_q;
    assign if_valid     = valid_q;
    assign pc           = pc_q;
    assign halted       = halted_q;
    assign fetch_fault  = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with an issue scoreboard.
module tb_instruction_fetch;

    localparam int MW = 256;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          PCSrc;
    logic [63:0]   BranchAddress;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic [31:0]   InstructionI;
    logic [63:0]   AddressI;
    logic          if_valid;
    logic [63:0]   pc;
    logic          halted;
    logic          fetch_fault;

    instruction_fetch #(.MEM_WORDS(MW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .PCSrc(PCSrc),
        .BranchAddress(BranchAddress), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data),
        .InstructionI(InstructionI), .AddressI(AddressI),
        .if_valid(if_valid), .pc(pc), .halted(halted),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [31:0] i;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [MW];
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] a);
        exp_t e;
        e.a = a;
        e.i = model[a[AW+1:2]];
        sb.push_back(e);
    endtask

    // One edge; a fresh issue is any valid output after a non-stalled edge
    task automatic tick();
        logic st;
        exp_t e;
        st = stall;
        @(posedge clk);
        #1;
        if (rst_n && if_valid && !st) begin
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL issue: observed addr %h expected none",
                       AddressI);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("issue_addr", AddressI, e.a);
                chk("issue_instr", {32'h0, InstructionI}, {32'h0, e.i});
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"}, pc, 64'h0);
        chk({tag, "_instr"}, {32'h0, InstructionI}, 64'h0);
        chk({tag, "_addr"}, AddressI, 64'h0);
        chk({tag, "_valid"}, {63'h0, if_valid}, 64'h0);
        chk({tag, "_halted"}, {63'h0, halted}, 64'h0);
        chk({tag, "_fault"}, {63'h0, fetch_fault}, 64'h0);
    endtask

    task automatic chk_halt(input string tag, input logic flt,
                            input logic [63:0] p);
        chk({tag, "_halted"}, {63'h0, halted}, 64'h1);
        chk({tag, "_fault"}, {63'h0, fetch_fault}, {63'h0, flt});
        chk({tag, "_valid"}, {63'h0, if_valid}, 64'h0);
        chk({tag, "_pc"}, pc, p);
    endtask

    task automatic redirect(input logic [63:0] t);
        PCSrc = 1'b1;
        BranchAddress = t;
        tick();
        PCSrc = 1'b0;
    endtask

    task automatic reset_boot();
        rst_n = 1'b0;
        tick();
        chk_reset("rst");
        rst_n = 1'b1;
        tick();
        chk("boot_pc", pc, 64'h0);
        chk("boot_valid", {63'h0, if_valid}, 64'h0);
    endtask

    logic [31:0] h_instr;
    logic [63:0] h_addr;
    logic [63:0] h_pc;

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        PCSrc = 1'b0;
        BranchAddress = '0;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;

        for (int k = 0; k < MW; k++) begin
            model[k] = 32'hA000_0000 | 32'(k);
        end
        model[0] = 32'h8B02_0020;
        model[1] = 32'hCB03_0041;
        model[2] = 32'hF840_0062;
        model[3] = 32'h0000_0000;
        model[5] = 32'h5555_0005;

        load_en = 1'b1;
        for (int k = 0; k < MW; k++) begin
            load_addr = AW'(k);
            load_data = model[k];
            tick();
        end
        load_en = 1'b0;

        // sequential fetch up to the halt marker
        reset_boot();
        push(64'h0);
        push(64'h4);
        push(64'h8);
        tick();
        tick();
        tick();
        tick();
        chk_halt("marker", 1'b0, 64'hC);
        chk("sb_seq", 64'(sb.size()), 64'h0);

        // HALT preload lands; redirect while halted is ignored
        load_en = 1'b1;
        load_addr = 8'd3;
        load_data = 32'h1111_0003;
        model[3] = 32'h1111_0003;
        PCSrc = 1'b1;
        BranchAddress = 64'h40;
        tick();
        PCSrc = 1'b0;
        load_en = 1'b0;
        chk_halt("halt_ign", 1'b0, 64'hC);

        // redirect from pc=8 to 0x20
        reset_boot();
        push(64'h0);
        push(64'h4);
        tick();
        tick();
        chk("pre_redir_pc", pc, 64'h8);
        redirect(64'h20);
        chk("redir_valid", {63'h0, if_valid}, 64'h0);
        chk("redir_pc", pc, 64'h20);
        push(64'h20);
        tick();

        // stall holds everything bit-exact
        h_instr = InstructionI;
        h_addr = AddressI;
        h_pc = pc;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_instr", {32'h0, InstructionI}, {32'h0, h_instr});
            chk("stall_addr", AddressI, h_addr);
            chk("stall_pc", pc, h_pc);
            chk("stall_valid", {63'h0, if_valid}, 64'h1);
        end
        redirect(64'h40);
        stall = 1'b0;
        chk("stredir_pc", pc, 64'h40);
        chk("stredir_valid", {63'h0, if_valid}, 64'h0);
        push(64'h40);
        tick();

        // preload during RUN must be dropped
        push(64'h44);
        load_en = 1'b1;
        load_addr = 8'd5;
        load_data = 32'hDEAD_BEEF;
        tick();
        load_en = 1'b0;
        redirect(64'h14);
        push(64'h14);
        tick();

        // reset mid-stream with valid output at pc=0x10
        redirect(64'hC);
        push(64'hC);
        tick();
        chk("mid_pc", pc, 64'h10);
        chk("mid_valid", {63'h0, if_valid}, 64'h1);
        load_en = 1'b1;
        load_addr = 8'd5;
        load_data = 32'hDEAD_BEEF;
        model[5] = 32'hDEAD_BEEF;
        reset_boot();
        load_en = 1'b0;
        push(64'h0);
        push(64'h4);
        tick();
        tick();
        redirect(64'h14);
        push(64'h14);
        tick();

        // misaligned redirect target
        redirect(64'h22);
        chk("mis_pc", pc, 64'h22);
        chk("mis_halted", {63'h0, halted}, 64'h0);
        tick();
        chk_halt("mis", 1'b1, 64'h22);

        // last legal word, then falling off the end
        reset_boot();
        redirect(64'h3FC);
        push(64'h3FC);
        tick();
        tick();
        chk_halt("end", 1'b1, 64'h400);

        // direct out-of-range redirect
        reset_boot();
        redirect(64'h400);
        chk("oor_valid", {63'h0, if_valid}, 64'h0);
        tick();
        chk_halt("oor", 1'b1, 64'h400);

        chk("sb_final", 64'(sb.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
